scumv_radar_frame_sequencer: RTL and testbench
==============================================

# scumv_radar_frame_sequencer

Hardware sequencer for the SCuM-V radar front end. It takes a latched frame configuration and drives the VCO, PA and ramp-generator control lines through a timed power-up, chirp and inter-frame-gap schedule, so software no longer toggles these bits one MMIO write at a time. It sits between the tuning register frontend, which supplies the configuration, and the radar analog control outputs. Its outputs are muxed in place of the static register values whenever `io_busy` is high.

## Interface
Parameters:
- `FRAME_W`, default 16: width of the frame count and frame index.
- `CHIRP_W`, default 8: width of the chirps-per-frame count and chirp index.

Ports:
- `clock`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-high.
- `io_start`, in, 1: start request, sampled only in IDLE.
- `io_abort`, in, 1: abort request, any state.
- `io_cfg_settleCycles`, in, 16: VCO settle time in cycles.
- `io_cfg_numFrequencySteps`, in, 8: ramp steps per chirp.
- `io_cfg_numCyclesPerFrequency`, in, 24: cycles per ramp step.
- `io_cfg_chirpsPerFrame`, in, CHIRP_W: chirps per frame.
- `io_cfg_gapCycles`, in, 32: inter-frame gap in cycles.
- `io_cfg_numFrames`, in, FRAME_W: frames to run; 0 means continuous.
- `io_vco_enable`, out, 1: VCO enable.
- `io_vco_divEnable`, out, 1: VCO divider enable.
- `io_pa_enable`, out, 1: PA enable.
- `io_ramp_rst`, out, 1: ramp-generator reset.
- `io_ramp_enable`, out, 1: ramp-generator enable.
- `io_busy`, out, 1: high in every state except IDLE.
- `io_frameStart`, out, 1: one-cycle pulse at the start of each frame.
- `io_chirpStart`, out, 1: one-cycle pulse at the start of each chirp.
- `io_done`, out, 1: one-cycle pulse on normal completion.
- `io_aborted`, out, 1: one-cycle pulse on abort.
- `io_cfgErr`, out, 1: one-cycle pulse when a start is rejected.
- `io_chirpIdx`, out, CHIRP_W: current chirp within the frame.
- `io_frameIdx`, out, FRAME_W: current frame.

## Operation
- All outputs are registered (Moore style).
- Reset value of every output is 0. State resets to IDLE.
- Configuration is captured into shadow registers on an accepted start. `io_cfg_*` changes while busy have no effect.
- Chirp length L = numFrequencySteps × numCyclesPerFrequency.
  - Computed once at start as an unsigned 32-bit product; the product never overflows.
- Start validation: start is rejected if numFrequencySteps, numCyclesPerFrequency or chirpsPerFrame is 0.
  - On rejection: `io_cfgErr` pulses, state stays IDLE.
- States:
  - IDLE: all enables are 0. On a valid start, go to SETTLE and clear both indices.
  - SETTLE: vco_enable = 1 and divEnable = 1. Lasts max(settleCycles, 1) cycles, then go to ARM.
  - ARM: 1 cycle. ramp_rst = 1 and pa_enable = 1. Next state is CHIRP.
    - `io_frameStart` pulses in this cycle when chirpIdx == 0.
  - CHIRP: ramp_enable = 1 and pa_enable = 1 for L cycles.
    - `io_chirpStart` pulses on the first cycle.
    - At the end: if chirpIdx == chirpsPerFrame−1, go to GAP; otherwise increment chirpIdx and go to ARM.
  - GAP: ramp_enable = 0 and pa_enable = 0; the VCO stays on. Lasts max(gapCycles, 1) cycles.
    - At the end: clear chirpIdx and increment frameIdx.
    - If numFrames ≠ 0 and the incremented value equals numFrames, go to IDLE and pulse `io_done` there.
    - Otherwise go to ARM.
- In continuous mode frameIdx wraps from all-ones to 0 and the sequencer never completes on its own.
- Abort: `io_abort` high in any non-IDLE state forces IDLE on the next edge.
  - All enables drop, `io_aborted` pulses, and `io_done` does not pulse.
  - Abort in IDLE is ignored.
  - Abort wins over any simultaneous completion. `io_done` and `io_aborted` are never both high.
- Start and abort both high in IDLE: the start is ignored and nothing pulses.
- Asynchronous reset mid-sequence drops every output to 0 immediately, without waiting for a clock edge.
- The timed-state counter is a 32-bit down-counter. It is loaded with (N−1) on entry to a state, and the state exits when the counter reads 0.

## Timing
- Start sampled at edge t: the state is SETTLE from cycle t+1 and `io_vco_enable` is high from t+1.
- Per-chirp period is 1 + L cycles.
- Frame period is chirpsPerFrame × (1 + L) + max(gapCycles, 1) cycles.
- Total run time from start to the `io_done` cycle is 1 + max(S, 1) + numFrames × frame period.
- No combinational path from any input to any output.

## Test plan
- Single frame. Config: S=3, steps=4, cpf=2 (L=8), chirps=2, gap=5, frames=1; start at cycle 0. Required:
  - vco_enable high in cycles 1–26.
  - ramp_rst at cycles 4 and 13.
  - ramp_enable in cycles 5–12 and 14–21.
  - `io_done` and busy low at cycle 27.
- Continuous mode. Same config with frames=0: frameStart pulses every 23 cycles, frameIdx increments after each gap, and done never pulses.
- Abort during the second CHIRP (cycle 16): all outputs 0 at cycle 17, aborted pulses at 17, done stays 0, and a new start is accepted afterwards.
- Config error. Start with chirps=0: `io_cfgErr` pulses at cycle 1, busy stays 0, and all enables stay 0.
- Config change while busy: change cpf to 9 mid-run; the current run's ramp_enable windows remain 8 cycles long.
- Reset mid-run: assert reset asynchronously during CHIRP; all outputs go to 0 before the next edge and the state is IDLE after deassertion.

Source files
------------

// File: rtl/scumv_radar_frame_sequencer.sv
// Timed VCO/PA/ramp control sequencer for the SCuM-V radar front end.
// Runs settle -> (arm, chirp) x chirpsPerFrame -> gap per frame from a shadowed config.
module scumv_radar_frame_sequencer #(
  parameter int FRAME_W = 16,
  parameter int CHIRP_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_start,
  input  logic               io_abort,
  input  logic [15:0]        io_cfg_settleCycles,
  input  logic [7:0]         io_cfg_numFrequencySteps,
  input  logic [23:0]        io_cfg_numCyclesPerFrequency,
  input  logic [CHIRP_W-1:0] io_cfg_chirpsPerFrame,
  input  logic [31:0]        io_cfg_gapCycles,
  input  logic [FRAME_W-1:0] io_cfg_numFrames,
  output logic               io_vco_enable,
  output logic               io_vco_divEnable,
  output logic               io_pa_enable,
  output logic               io_ramp_rst,
  output logic               io_ramp_enable,
  output logic               io_busy,
  output logic               io_frameStart,
  output logic               io_chirpStart,
  output logic               io_done,
  output logic               io_aborted,
  output logic               io_cfgErr,
  output logic [CHIRP_W-1:0] io_chirpIdx,
  output logic [FRAME_W-1:0] io_frameIdx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ARM,
    S_CHIRP,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [31:0]        len_q, len_d;
  logic [31:0]        gap_q, gap_d;
  logic [CHIRP_W-1:0] cpf_q, cpf_d;
  logic [FRAME_W-1:0] nf_q, nf_d;
  logic [CHIRP_W-1:0] chirp_q, chirp_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [FRAME_W-1:0] frame_inc;
  logic               cfg_ok;
  logic               done_d, aborted_d, cfgerr_d, fstart_d, cstart_d;

  logic vco_q, div_q, pa_q, rrst_q, ren_q, busy_q;
  logic fstart_q, cstart_q, done_q, aborted_q, cfgerr_q;

  assign frame_inc = frame_q + FRAME_W'(1);
  assign cfg_ok    = (io_cfg_numFrequencySteps != '0) &&
                     (io_cfg_numCyclesPerFrequency != '0) &&
                     (io_cfg_chirpsPerFrame != '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    gap_d     = gap_q;
    cpf_d     = cpf_q;
    nf_d      = nf_q;
    chirp_d   = chirp_q;
    frame_d   = frame_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    cfgerr_d  = 1'b0;

    if (state_q == S_IDLE) begin
      // A simultaneous abort cancels the start outright, including the error pulse.
      if (io_start && !io_abort) begin
        if (!cfg_ok) begin
          cfgerr_d = 1'b1;
        end else begin
          state_d = S_SETTLE;
          cnt_d   = (io_cfg_settleCycles == '0) ? '0 : 32'(io_cfg_settleCycles) - 32'd1;
          len_d   = 32'(io_cfg_numFrequencySteps) * 32'(io_cfg_numCyclesPerFrequency);
          gap_d   = io_cfg_gapCycles;
          cpf_d   = io_cfg_chirpsPerFrame;
          nf_d    = io_cfg_numFrames;
          chirp_d = '0;
          frame_d = '0;
        end
      end
    end else if (io_abort) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      chirp_d   = '0;
      frame_d   = '0;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        S_SETTLE: begin
          if (cnt_q == '0) state_d = S_ARM;
          else             cnt_d   = cnt_q - 32'd1;
        end
        S_ARM: begin
          state_d = S_CHIRP;
          cnt_d   = len_q - 32'd1;
        end
        S_CHIRP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 32'd1;
          end else if (chirp_q == cpf_q - CHIRP_W'(1)) begin
            state_d = S_GAP;
            cnt_d   = (gap_q == '0) ? '0 : gap_q - 32'd1;
          end else begin
            state_d = S_ARM;
            chirp_d = chirp_q + CHIRP_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 32'd1;
          end else begin
            chirp_d = '0;
            frame_d = frame_inc;
            if (nf_q != '0 && frame_inc == nf_q) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_ARM;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    fstart_d = (state_d == S_ARM) && (chirp_d == '0);
    cstart_d = (state_d == S_CHIRP) && (state_q == S_ARM);
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      cpf_q     <= '0;
      nf_q      <= '0;
      chirp_q   <= '0;
      frame_q   <= '0;
      vco_q     <= 1'b0;
      div_q     <= 1'b0;
      pa_q      <= 1'b0;
      rrst_q    <= 1'b0;
      ren_q     <= 1'b0;
      busy_q    <= 1'b0;
      fstart_q  <= 1'b0;
      cstart_q  <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cfgerr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      cpf_q     <= cpf_d;
      nf_q      <= nf_d;
      chirp_q   <= chirp_d;
      frame_q   <= frame_d;
      vco_q     <= (state_d != S_IDLE);
      div_q     <= (state_d != S_IDLE);
      pa_q      <= (state_d == S_ARM) || (state_d == S_CHIRP);
      rrst_q    <= (state_d == S_ARM);
      ren_q     <= (state_d == S_CHIRP);
      busy_q    <= (state_d != S_IDLE);
      fstart_q  <= fstart_d;
      cstart_q  <= cstart_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      cfgerr_q  <= cfgerr_d;
    end
  end

  assign io_vco_enable    = vco_q;
  assign io_vco_divEnable = div_q;
  assign io_pa_enable     = pa_q;
  assign io_ramp_rst      = rrst_q;
  assign io_ramp_enable   = ren_q;
  assign io_busy          = busy_q;
  assign io_frameStart    = fstart_q;
  assign io_chirpStart    = cstart_q;
  assign io_done          = done_q;
  assign io_aborted       = aborted_q;
  assign io_cfgErr        = cfgerr_q;
  assign io_chirpIdx      = chirp_q;
  assign io_frameIdx      = frame_q;

endmodule

// File: tb/tb_scumv_radar_frame_sequencer.sv
// Self-checking bench: per-cycle outputs compared to a schedule computed arithmetically
// from the captured frame configuration.
module tb_scumv_radar_frame_sequencer;
  localparam int FW   = 4;
  localparam int CW   = 8;
  localparam int FMOD = 1 << FW;

  localparam int V  = 10, D = 9, PA = 8, RR = 7, RE = 6, B = 5;
  localparam int FS = 4, CS = 3, DN = 2, AB = 1, CE = 0;

  typedef struct {
    int unsigned s, steps, cpc, cpf, gap, nf;
  } cfg_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          io_start, io_abort;
  logic [15:0]   io_cfg_settleCycles;
  logic [7:0]    io_cfg_numFrequencySteps;
  logic [23:0]   io_cfg_numCyclesPerFrequency;
  logic [CW-1:0] io_cfg_chirpsPerFrame;
  logic [31:0]   io_cfg_gapCycles;
  logic [FW-1:0] io_cfg_numFrames;
  logic          io_vco_enable, io_vco_divEnable, io_pa_enable, io_ramp_rst, io_ramp_enable;
  logic          io_busy, io_frameStart, io_chirpStart, io_done, io_aborted, io_cfgErr;
  logic [CW-1:0] io_chirpIdx;
  logic [FW-1:0] io_frameIdx;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  scumv_radar_frame_sequencer #(.FRAME_W(FW), .CHIRP_W(CW)) dut (
    .clock                        (clock),
    .reset                        (reset),
    .io_start                     (io_start),
    .io_abort                     (io_abort),
    .io_cfg_settleCycles          (io_cfg_settleCycles),
    .io_cfg_numFrequencySteps     (io_cfg_numFrequencySteps),
    .io_cfg_numCyclesPerFrequency (io_cfg_numCyclesPerFrequency),
    .io_cfg_chirpsPerFrame        (io_cfg_chirpsPerFrame),
    .io_cfg_gapCycles             (io_cfg_gapCycles),
    .io_cfg_numFrames             (io_cfg_numFrames),
    .io_vco_enable                (io_vco_enable),
    .io_vco_divEnable             (io_vco_divEnable),
    .io_pa_enable                 (io_pa_enable),
    .io_ramp_rst                  (io_ramp_rst),
    .io_ramp_enable               (io_ramp_enable),
    .io_busy                      (io_busy),
    .io_frameStart                (io_frameStart),
    .io_chirpStart                (io_chirpStart),
    .io_done                      (io_done),
    .io_aborted                   (io_aborted),
    .io_cfgErr                    (io_cfgErr),
    .io_chirpIdx                  (io_chirpIdx),
    .io_frameIdx                  (io_frameIdx)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [10:0] outv();
    return {io_vco_enable, io_vco_divEnable, io_pa_enable, io_ramp_rst, io_ramp_enable,
            io_busy, io_frameStart, io_chirpStart, io_done, io_aborted, io_cfgErr};
  endfunction

  // Expected outputs k cycles after the start edge, from the frame schedule arithmetic.
  task automatic model(input cfg_t c, input int unsigned k, output logic [10:0] v,
                       output int unsigned ci, output int unsigned fi);
    int unsigned sx, g, l, p, t, j, r, w;
    sx = (c.s == 0) ? 1 : c.s;
    g  = (c.gap == 0) ? 1 : c.gap;
    l  = c.steps * c.cpc;
    p  = c.cpf * (1 + l) + g;
    t  = 1 + sx + c.nf * p;
    v  = '0;
    ci = 0;
    fi = 0;
    if (c.nf != 0 && k >= t) begin
      fi = c.nf % FMOD;
      if (k == t) v[DN] = 1'b1;
    end else if (k <= sx) begin
      v[V] = 1'b1; v[D] = 1'b1; v[B] = 1'b1;
    end else begin
      j  = k - 1 - sx;
      fi = (j / p) % FMOD;
      r  = j % p;
      v[V] = 1'b1; v[D] = 1'b1; v[B] = 1'b1;
      if (r < c.cpf * (1 + l)) begin
        ci = r / (1 + l);
        w  = r % (1 + l);
        v[PA] = 1'b1;
        if (w == 0) begin
          v[RR] = 1'b1;
          v[FS] = (ci == 0);
        end else begin
          v[RE] = 1'b1;
          v[CS] = (w == 1);
        end
      end else begin
        ci = c.cpf - 1;
      end
    end
  endtask

  function automatic int unsigned run_len(input cfg_t c);
    int unsigned sx, g, l;
    sx = (c.s == 0) ? 1 : c.s;
    g  = (c.gap == 0) ? 1 : c.gap;
    l  = c.steps * c.cpc;
    return 1 + sx + c.nf * (c.cpf * (1 + l) + g);
  endfunction

  task automatic drive_cfg(input cfg_t c);
    io_cfg_settleCycles          = 16'(c.s);
    io_cfg_numFrequencySteps     = 8'(c.steps);
    io_cfg_numCyclesPerFrequency = 24'(c.cpc);
    io_cfg_chirpsPerFrame        = CW'(c.cpf);
    io_cfg_gapCycles             = c.gap;
    io_cfg_numFrames             = FW'(c.nf);
  endtask

  task automatic scramble_cfg();
    io_cfg_settleCycles          = 16'($urandom);
    io_cfg_numFrequencySteps     = 8'($urandom);
    io_cfg_numCyclesPerFrequency = 24'($urandom);
    io_cfg_chirpsPerFrame        = CW'($urandom);
    io_cfg_gapCycles             = $urandom;
    io_cfg_numFrames             = FW'($urandom);
  endtask

  // Starts c, checks every cycle up to ncyc; abort_at != 0 raises abort during that cycle.
  task automatic run(input string tag, input cfg_t c, input int unsigned ncyc,
                     input int unsigned abort_at);
    logic [10:0] v;
    int unsigned ci, fi;
    @(negedge clock);
    drive_cfg(c);
    io_start = 1'b1;
    @(negedge clock);
    io_start = 1'b0;
    for (int unsigned k = 1; k <= ncyc; k++) begin
      model(c, k, v, ci, fi);
      check({tag, ".out"}, 64'(outv()), 64'(v));
      check({tag, ".chirpIdx"}, 64'(io_chirpIdx), 64'(ci));
      check({tag, ".frameIdx"}, 64'(io_frameIdx), 64'(fi));
      if (k == abort_at) io_abort = 1'b1;
      scramble_cfg();
      @(negedge clock);
    end
    io_abort = 1'b0;
    if (abort_at != 0) begin
      check({tag, ".abort_out"}, 64'(outv()), 64'(11'd1 << AB));
      check({tag, ".abort_idx"}, 64'({io_chirpIdx, io_frameIdx}), 64'(0));
      @(negedge clock);
      check({tag, ".post_abort"}, 64'(outv()), 64'(0));
    end else begin
      check({tag, ".post_done"}, 64'(outv()), 64'(0));
      check({tag, ".post_done_fi"}, 64'(io_frameIdx), 64'(c.nf % FMOD));
    end
  endtask

  task automatic idle_probe(input string tag, input cfg_t c, input logic abort_too,
                            input logic [10:0] exp1);
    @(negedge clock);
    drive_cfg(c);
    io_start = 1'b1;
    io_abort = abort_too;
    @(negedge clock);
    io_start = 1'b0;
    io_abort = 1'b0;
    check({tag, ".c1"}, 64'(outv()), 64'(exp1));
    @(negedge clock);
    check({tag, ".c2"}, 64'(outv()), 64'(0));
  endtask

  cfg_t base, c;

  initial begin
    reset    = 1'b1;
    io_start = 1'b0;
    io_abort = 1'b0;
    base     = '{s: 3, steps: 4, cpc: 2, cpf: 2, gap: 5, nf: 1};
    drive_cfg(base);
    #12;
    check("reset.out", 64'(outv()), 64'(0));
    check("reset.idx", 64'({io_chirpIdx, io_frameIdx}), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("idle.out", 64'(outv()), 64'(0));

    run("single", base, 27, 0);

    c = base; c.nf = 0;
    run("contin", c, 3 * 23 + 6, 3 * 23 + 6);

    run("abort16", base, 16, 0 + 16);
    run("abort_gapend", base, 26, 26);
    run("after_abort", base, 27, 0);

    c = base; c.cpf = 0;   idle_probe("cfgerr_cpf",   c, 1'b0, 11'd1 << CE);
    c = base; c.steps = 0; idle_probe("cfgerr_steps", c, 1'b0, 11'd1 << CE);
    c = base; c.cpc = 0;   idle_probe("cfgerr_cpc",   c, 1'b0, 11'd1 << CE);
    idle_probe("start_abort", base, 1'b1, 11'd0);

    @(negedge clock);
    io_abort = 1'b1;
    @(negedge clock);
    io_abort = 1'b0;
    check("idle_abort", 64'(outv()), 64'(0));

    c = '{s: 0, steps: 1, cpc: 1, cpf: 1, gap: 0, nf: 0};
    run("wrap", c, 60, 60);
    c.nf = 15;
    run("nf_max", c, run_len(c), 0);

    for (int i = 0; i < 20; i++) begin
      int unsigned a;
      c.s     = $urandom_range(0, 6);
      c.steps = $urandom_range(1, 4);
      c.cpc   = $urandom_range(1, 4);
      c.cpf   = $urandom_range(1, 3);
      c.gap   = $urandom_range(0, 6);
      c.nf    = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        a = $urandom_range(1, run_len(c) - 1);
        run("rand_abort", c, a, a);
      end else begin
        run("rand_done", c, run_len(c), 0);
      end
    end

    @(negedge clock);
    drive_cfg(base);
    io_start = 1'b1;
    @(negedge clock);
    io_start = 1'b0;
    repeat (6) @(negedge clock);
    check("midrun.ramp", 64'(io_ramp_enable), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("async_reset.out", 64'(outv()), 64'(0));
    check("async_reset.idx", 64'({io_chirpIdx, io_frameIdx}), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_reset.out", 64'(outv()), 64'(0));
    run("post_reset_run", base, 27, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
